// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter and sequencer for a single-port memory.
// Optional WAIT-state timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int DATA_WIDTH       = 32,
   parameter int ADDR_WIDTH       = 32,
   parameter int CACHE_LINE_WIDTH = 256,
   parameter int STRB_WIDTH       = 8,
   parameter int TIMEOUT_CYCLES   = 64
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_ic_read_req,
   input  logic [ADDR_WIDTH-1:0]       i_ic_read_address,
   output logic                        o_ic_read_done,
   output logic [CACHE_LINE_WIDTH-1:0] o_ic_cache_line,
   input  logic                        i_dc_read_req,
   input  logic [ADDR_WIDTH-1:0]       i_dc_read_address,
   output logic                        o_dc_read_done,
   output logic [CACHE_LINE_WIDTH-1:0] o_dc_cache_line,
   input  logic                        i_dc_write_valid,
   input  logic [ADDR_WIDTH-1:0]       i_dc_write_address,
   input  logic [DATA_WIDTH-1:0]       i_dc_write_data,
   input  logic [STRB_WIDTH-1:0]       i_dc_write_strobe,
   output logic                        o_dc_write_done,
   output logic                        o_mem_read_req,
   output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
   input  logic                        i_mem_read_done,
   input  logic [CACHE_LINE_WIDTH-1:0] i_mem_cache_line,
   output logic                        o_mem_write_valid,
   output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
   output logic [DATA_WIDTH-1:0]       o_mem_write_data,
   output logic [STRB_WIDTH-1:0]       o_mem_write_strobe,
   input  logic                        i_mem_write_done,
   output logic                        o_busy,
`ifdef MEM_ARB_TIMEOUT_EN
   output logic [1:0]                  o_grant,
   output logic                        o_timeout
`else
   output logic [1:0]                  o_grant
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                      state_q, state_d;
   logic [1:0]                  grant_q, grant_d;
   logic                        wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic [DATA_WIDTH-1:0]       data_q, data_d;
   logic [STRB_WIDTH-1:0]       strb_q, strb_d;
   logic                        last_ic_q, last_ic_d;
   logic [CACHE_LINE_WIDTH-1:0] ic_line_q, ic_line_d;
   logic [CACHE_LINE_WIDTH-1:0] dc_line_q, dc_line_d;
   logic                        ic_pend, dc_pend, pick_ic, mem_done;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         last_ic_q <= 1'b0;
         ic_line_q <= '0;
         dc_line_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         to_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         strb_q    <= strb_d;
         last_ic_q <= last_ic_d;
         ic_line_q <= ic_line_d;
         dc_line_q <= dc_line_d;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         to_q      <= to_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      data_d    = data_q;
      strb_d    = strb_q;
      last_ic_d = last_ic_q;
      ic_line_d = ic_line_q;
      dc_line_d = dc_line_q;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      to_d      = to_q;
`endif
      ic_pend   = i_ic_read_req;
      dc_pend   = i_dc_write_valid | i_dc_read_req;
      // The port served last yields when both are pending.
      pick_ic   = ic_pend & (~dc_pend | ~last_ic_q);
      mem_done  = wr_q ? i_mem_write_done : i_mem_read_done;

      case (state_q)
         S_IDLE: begin
            if (ic_pend || dc_pend) begin
               state_d = S_ISSUE;
               data_d  = '0;
               strb_d  = '0;
               if (pick_ic) begin
                  grant_d = 2'b01;
                  wr_d    = 1'b0;
                  addr_d  = i_ic_read_address;
               end else if (i_dc_write_valid) begin
                  grant_d = 2'b10;
                  wr_d    = 1'b1;
                  addr_d  = i_dc_write_address;
                  data_d  = i_dc_write_data;
                  strb_d  = i_dc_write_strobe;
               end else begin
                  grant_d = 2'b10;
                  wr_d    = 1'b0;
                  addr_d  = i_dc_read_address;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_d   = '0;
            to_d    = 1'b0;
`endif
         end
         S_WAIT: begin
            if (mem_done) begin
               state_d = S_RESP;
               if (!wr_q && grant_q[0]) ic_line_d = i_mem_cache_line;
               if (!wr_q && grant_q[1]) dc_line_d = i_mem_cache_line;
`ifdef MEM_ARB_TIMEOUT_EN
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_RESP;
               to_d    = 1'b1;
               if (!wr_q && grant_q[0]) ic_line_d = '1;
               if (!wr_q && grant_q[1]) dc_line_d = '1;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         S_RESP: begin
            // Clearing the payload here keeps the memory-side outputs at 0 in IDLE.
            state_d   = S_IDLE;
            last_ic_d = grant_q[0];
            grant_d   = '0;
            wr_d      = 1'b0;
            addr_d    = '0;
            data_d    = '0;
            strb_d    = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_mem_read_req      = (state_q == S_ISSUE) && !wr_q;
   assign o_mem_write_valid   = (state_q == S_ISSUE) && wr_q;
   assign o_mem_read_address  = addr_q;
   assign o_mem_write_address = addr_q;
   assign o_mem_write_data    = data_q;
   assign o_mem_write_strobe  = strb_q;
   assign o_ic_read_done      = (state_q == S_RESP) && grant_q[0];
   assign o_dc_read_done      = (state_q == S_RESP) && grant_q[1] && !wr_q;
   assign o_dc_write_done     = (state_q == S_RESP) && grant_q[1] && wr_q;
   assign o_ic_cache_line     = ic_line_q;
   assign o_dc_cache_line     = dc_line_q;
   assign o_busy              = (state_q != S_IDLE);
   assign o_grant             = grant_q;
`ifdef MEM_ARB_TIMEOUT_EN
   assign o_timeout           = (state_q == S_RESP) && to_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: agents, a memory responder and a cycle-timed
// transaction model predicting grant order, memory strobes, done pulses and lines.
module tb_mem_arbiter;
   localparam int AW = 32, DW = 32, LW = 256, SW = 8, TO = 64, NCYC = 3000;
   localparam int NEVER = 32'h7fffffff;

   logic i_clk = 1'b0, i_rst_n = 1'b0;
   logic i_ic_read_req = 1'b0, i_dc_read_req = 1'b0, i_dc_write_valid = 1'b0;
   logic [AW-1:0] i_ic_read_address = '0, i_dc_read_address = '0, i_dc_write_address = '0;
   logic [DW-1:0] i_dc_write_data = '0;
   logic [SW-1:0] i_dc_write_strobe = '0;
   logic i_mem_read_done = 1'b0, i_mem_write_done = 1'b0;
   logic [LW-1:0] i_mem_cache_line = '0;
   logic o_ic_read_done, o_dc_read_done, o_dc_write_done, o_mem_read_req, o_mem_write_valid, o_busy;
   logic [LW-1:0] o_ic_cache_line, o_dc_cache_line;
   logic [AW-1:0] o_mem_read_address, o_mem_write_address;
   logic [DW-1:0] o_mem_write_data;
   logic [SW-1:0] o_mem_write_strobe;
   logic [1:0] o_grant;
`ifdef MEM_ARB_TIMEOUT_EN
   logic o_timeout;
`endif

   always #5 i_clk = ~i_clk;

   mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_LINE_WIDTH(LW),
                 .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_ic_read_req(i_ic_read_req), .i_ic_read_address(i_ic_read_address),
      .o_ic_read_done(o_ic_read_done), .o_ic_cache_line(o_ic_cache_line),
      .i_dc_read_req(i_dc_read_req), .i_dc_read_address(i_dc_read_address),
      .o_dc_read_done(o_dc_read_done), .o_dc_cache_line(o_dc_cache_line),
      .i_dc_write_valid(i_dc_write_valid), .i_dc_write_address(i_dc_write_address),
      .i_dc_write_data(i_dc_write_data), .i_dc_write_strobe(i_dc_write_strobe),
      .o_dc_write_done(o_dc_write_done),
      .o_mem_read_req(o_mem_read_req), .o_mem_read_address(o_mem_read_address),
      .i_mem_read_done(i_mem_read_done), .i_mem_cache_line(i_mem_cache_line),
      .o_mem_write_valid(o_mem_write_valid), .o_mem_write_address(o_mem_write_address),
      .o_mem_write_data(o_mem_write_data), .o_mem_write_strobe(o_mem_write_strobe),
      .i_mem_write_done(i_mem_write_done), .o_busy(o_busy),
`ifdef MEM_ARB_TIMEOUT_EN
      .o_grant(o_grant), .o_timeout(o_timeout)
`else
      .o_grant(o_grant)
`endif
   );

   int errors = 0, checks = 0, cyc = 0;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   // Transaction model state
   bit            last_ic, inflight, rst_done, pick_ic, exp_to;
   bit            ic_drop, dcr_drop, dcw_drop;
   int            free_cycle, strobe_cycle, mem_done_cycle, done_cycle, quiet_until;
   logic          exp_wr;
   logic [1:0]    exp_owner;
   logic [2:0]    exp_done;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_data;
   logic [SW-1:0] exp_strb;
   logic [LW-1:0] exp_line, m_ic_line, m_dc_line;

   task automatic model_reset();
      last_ic = 0; inflight = 0; exp_to = 0;
      strobe_cycle = -1; mem_done_cycle = -1; done_cycle = -1;
      free_cycle = cyc;
      m_ic_line = '0; m_dc_line = '0;
   endtask

   task automatic clear_inputs();
      i_ic_read_req = 0; i_dc_read_req = 0; i_dc_write_valid = 0;
      i_mem_read_done = 0; i_mem_write_done = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, LW'({o_busy, o_grant, o_ic_read_done, o_dc_read_done, o_dc_write_done,
                               o_mem_read_req, o_mem_write_valid}), '0);
      check({tag, "_payload"}, LW'({o_mem_read_address, o_mem_write_address,
                                   o_mem_write_data, o_mem_write_strobe}), '0);
      check({tag, "_ic_line"}, o_ic_cache_line, '0);
      check({tag, "_dc_line"}, o_dc_cache_line, '0);
`ifdef MEM_ARB_TIMEOUT_EN
      check({tag, "_timeout"}, LW'(o_timeout), '0);
`endif
   endtask

   initial begin
      repeat (3) @(posedge i_clk);
      #1;
      check_all_zero("reset");
      i_rst_n = 1'b1;
      cyc = 0;
      quiet_until = 0;
      rst_done = 0;
      model_reset();

      while (cyc < NCYC) begin
         ic_drop = 0; dcr_drop = 0; dcw_drop = 0;

         // Memory-side strobe expected exactly one cycle after a grant sample.
         if (cyc == strobe_cycle) begin
            check("mem_strobe", LW'({o_mem_read_req, o_mem_write_valid}), LW'(exp_wr ? 2'b01 : 2'b10));
            check("grant", LW'(o_grant), LW'(exp_owner));
            if (exp_wr) begin
               check("wr_addr", LW'(o_mem_write_address), LW'(exp_addr));
               check("wr_data", LW'(o_mem_write_data), LW'(exp_data));
               check("wr_strb", LW'(o_mem_write_strobe), LW'(exp_strb));
            end else begin
               check("rd_addr", LW'(o_mem_read_address), LW'(exp_addr));
            end
            inflight = 1;
            exp_to = 0;
            mem_done_cycle = cyc + 1 + int'($urandom_range(0, 2));
`ifdef MEM_ARB_TIMEOUT_EN
            if ($urandom_range(0, 5) == 0) begin
               mem_done_cycle = -1;
               done_cycle = cyc + TO + 1;
               exp_to = 1;
               exp_line = '1;
            end
`endif
         end else begin
            check("mem_quiet", LW'({o_mem_read_req, o_mem_write_valid}), '0);
         end

         exp_done = 3'b000;
         if (cyc == done_cycle) begin
            exp_done = exp_owner[0] ? 3'b100 : (exp_wr ? 3'b001 : 3'b010);
            if (!exp_wr && exp_owner[0]) m_ic_line = exp_line;
            if (!exp_wr && exp_owner[1]) m_dc_line = exp_line;
         end
         check("done", LW'({o_ic_read_done, o_dc_read_done, o_dc_write_done}), LW'(exp_done));
         check("ic_line", o_ic_cache_line, m_ic_line);
         check("dc_line", o_dc_cache_line, m_dc_line);
`ifdef MEM_ARB_TIMEOUT_EN
         check("timeout", LW'(o_timeout), LW'((cyc == done_cycle) && exp_to));
`endif
         if (cyc < quiet_until) check("idle_after_reset", LW'(o_busy), '0);

         if (cyc == done_cycle) begin
            inflight = 0;
            free_cycle = cyc + 1;
            if (exp_owner[0]) begin i_ic_read_req = 0; ic_drop = 1; end
            else if (exp_wr)  begin i_dc_write_valid = 0; dcw_drop = 1; end
            else              begin i_dc_read_req = 0; dcr_drop = 1; end
         end

         // Reset in the first WAIT cycle of an IC read abandons it.
         if (!rst_done && cyc > 1000 && inflight && cyc == strobe_cycle + 1 && exp_owner == 2'b01) begin
            rst_done = 1;
            i_rst_n = 1'b0;
            clear_inputs();
            #1;
            check_all_zero("mid_reset");
            tick();
            tick();
            i_rst_n = 1'b1;
            model_reset();
            quiet_until = cyc + 8;
         end

         if (cyc == 0) begin
            i_ic_read_req = 1; i_ic_read_address = $urandom;
            i_dc_read_req = 1; i_dc_read_address = $urandom;
         end else if (cyc >= quiet_until) begin
            if (!i_ic_read_req && !ic_drop && $urandom_range(0, 2) == 0) begin
               i_ic_read_req = 1; i_ic_read_address = $urandom;
            end
            if (!i_dc_write_valid && !dcw_drop && $urandom_range(0, 3) == 0) begin
               i_dc_write_valid = 1; i_dc_write_address = $urandom;
               i_dc_write_data = $urandom; i_dc_write_strobe = SW'($urandom);
            end
            if (!i_dc_read_req && !dcr_drop && $urandom_range(0, 3) == 0) begin
               i_dc_read_req = 1; i_dc_read_address = $urandom;
            end
         end

         // Payload of the granted request is disturbed after grant.
         if (o_grant == 2'b01 && i_ic_read_req && $urandom_range(0, 1) == 1)
            i_ic_read_address = $urandom;
         if (o_grant == 2'b10 && $urandom_range(0, 1) == 1) begin
            if (exp_wr && i_dc_write_valid) begin
               i_dc_write_address = $urandom; i_dc_write_data = $urandom;
               i_dc_write_strobe = SW'($urandom);
            end else if (!exp_wr && i_dc_read_req) begin
               i_dc_read_address = $urandom;
            end
         end

         // Memory responder with ignored-done noise.
         i_mem_read_done = 0;
         i_mem_write_done = 0;
         i_mem_cache_line = {8{$urandom}};
         if (inflight && cyc == mem_done_cycle) begin
            if (exp_wr) i_mem_write_done = 1; else i_mem_read_done = 1;
            exp_line = i_mem_cache_line;
            done_cycle = cyc + 1;
         end else if ($urandom_range(0, 3) == 0) begin
            if (!inflight) {i_mem_read_done, i_mem_write_done} = 2'($urandom_range(1, 3));
            else if (exp_wr) i_mem_read_done = 1;
            else i_mem_write_done = 1;
         end

         if (cyc >= free_cycle && (i_ic_read_req || i_dc_write_valid || i_dc_read_req)) begin
            pick_ic = i_ic_read_req && (!(i_dc_write_valid || i_dc_read_req) || !last_ic);
            last_ic = pick_ic;
            exp_data = '0;
            exp_strb = '0;
            if (pick_ic) begin
               exp_owner = 2'b01; exp_wr = 0; exp_addr = i_ic_read_address;
            end else if (i_dc_write_valid) begin
               exp_owner = 2'b10; exp_wr = 1; exp_addr = i_dc_write_address;
               exp_data = i_dc_write_data; exp_strb = i_dc_write_strobe;
            end else begin
               exp_owner = 2'b10; exp_wr = 0; exp_addr = i_dc_read_address;
            end
            $display("grant cycle=%0d owner=%b write=%0d addr=%h", cyc, exp_owner, exp_wr, exp_addr);
            strobe_cycle = cyc + 1;
            free_cycle = NEVER;
         end

         tick();
      end

      check("reset_exercised", LW'(rst_done), LW'(1'b1));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
